// File: rtl/wb_sram_bridge.sv
// Wishbone B4 classic slave bridging the management SoC to port 0 (RW) of a
// single-port SRAM macro. Decodes a base-address window and runs one SRAM
// access per bus transaction. Returns a single-cycle ack.
// All outputs come straight from flops.
module wb_sram_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic                    ack_reg, ack_next;
    logic [DATA_WIDTH-1:0]   dat_o_reg, dat_o_next;
    logic                    csb_reg, csb_next;
    logic                    web_reg, web_next;
    logic [NUM_WMASKS-1:0]   wmask_reg, wmask_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   din_reg, din_next;

    logic                    hit;
    logic [NUM_WMASKS-1:0]   req_wmask;

    // Byte offset bits never reach the word-addressed SRAM.
    logic unused_byte_offset;
    assign unused_byte_offset = ^wbs_adr_i[1:0];

    // Window decode: only the bits above the word index must match the base.
    assign hit = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // Per-lane write mask: reads must never present a nonzero mask.
    generate
        for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_lane_mask
            assign req_wmask[gi] = wbs_we_i & wbs_sel_i[gi];
        end
    endgenerate

    // State and output registers; reset forces the idle bus/SRAM values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            dat_o_reg <= '0;
            csb_reg   <= 1'b1;
            web_reg   <= 1'b1;
            wmask_reg <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            dat_o_reg <= dat_o_next;
            csb_reg   <= csb_next;
            web_reg   <= web_next;
            wmask_reg <= wmask_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
        end
    end

    // Next-state logic: requests are only sampled in IDLE, so a strobe held
    // through the ack cycle cannot launch a second access.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (hit) state_next = ACCESS;
            ACCESS:  state_next = web_reg ? RDWAIT : ACK;
            RDWAIT:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next-output logic: chip select is low for exactly the one cycle that
    // leads into the SRAM capture edge; address/data simply hold afterwards.
    always_comb begin
        ack_next   = 1'b0;
        dat_o_next = dat_o_reg;
        csb_next   = 1'b1;
        web_next   = 1'b1;
        wmask_next = '0;
        addr_next  = addr_reg;
        din_next   = din_reg;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    csb_next   = 1'b0;
                    web_next   = ~wbs_we_i;
                    wmask_next = req_wmask;
                    addr_next  = wbs_adr_i[ADDR_WIDTH+1:2];
                    din_next   = wbs_dat_i;
                end
            end
            ACCESS: begin
                // web_reg still reflects the access the SRAM is capturing now.
                ack_next = ~web_reg;
            end
            RDWAIT: begin
                // Read data was launched on the falling edge after capture.
                ack_next   = 1'b1;
                dat_o_next = sram_dout0;
            end
            default: begin
                ack_next = 1'b0;
            end
        endcase
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_o_reg;
    assign sram_csb0   = csb_reg;
    assign sram_web0   = web_reg;
    assign sram_wmask0 = wmask_reg;
    assign sram_addr0  = addr_reg;
    assign sram_din0   = din_reg;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed testbench for wb_sram_bridge with a behavioural 32x512 SRAM model
// (inputs captured on rising edge, read data launched on falling edge).
module tb_wb_sram_bridge;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    int tests_run    = 0;
    int tests_failed = 0;
    int ack_cnt      = 0;
    int csb_low_cnt  = 0;

    always #5 clk = ~clk;

    wb_sram_bridge dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // SRAM model
    logic [31:0] mem [0:511];
    logic        rd_pend = 1'b0;
    logic [8:0]  rd_addr = '0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        sram_dout0 = 32'h0;
    end

    always @(posedge clk) begin
        if (sram_csb0 === 1'b0) begin
            if (sram_web0 === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end
            rd_pend <= (sram_web0 === 1'b1);
            rd_addr <= sram_addr0;
        end else begin
            rd_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rd_pend) sram_dout0 <= mem[rd_addr];
    end

    // Activity monitor: ack pulses and chip-select-low cycles
    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1) ack_cnt++;
        if (sram_csb0 === 1'b0) csb_low_cnt++;
    end

    // Bus driver; caller is just past a rising edge. Returns edges from the
    // request-sample edge to the edge where ack is seen (0 = never acked).
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit keep,
                           output logic [31:0] rdata, output int lat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        lat = 0; rdata = '0;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (wbs_ack_o === 1'b1) begin
                lat = i + 1;
                rdata = wbs_dat_o;
                break;
            end
        end
        @(posedge clk); #1;
        if (!keep) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0", wbs_ack_o); end
        tests_run++; if (sram_csb0 !== 1'b1) begin tests_failed++; $display("FAIL reset_csb got=%b exp=1", sram_csb0); end
        tests_run++; if (sram_web0 !== 1'b1) begin tests_failed++; $display("FAIL reset_web got=%b exp=1", sram_web0); end
        tests_run++; if (sram_wmask0 !== 4'h0) begin tests_failed++; $display("FAIL reset_wmask got=%h exp=0", sram_wmask0); end
        tests_run++; if (wbs_dat_o !== 32'h0) begin tests_failed++; $display("FAIL reset_dat_o got=%h exp=0", wbs_dat_o); end
        tests_run++; if (sram_addr0 !== 9'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", sram_addr0); end
        tests_run++; if (sram_din0 !== 32'h0) begin tests_failed++; $display("FAIL reset_din got=%h exp=0", sram_din0); end
        $display("[TB] reset: ack=%b csb=%b web=%b wmask=%h dat_o=%h", wbs_ack_o, sram_csb0, sram_web0, sram_wmask0, wbs_dat_o);
        wb_rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat, a0, c0;
        a0 = ack_cnt; c0 = csb_low_cnt;
        wb_xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat);
        $display("[TB] write 3000_0010 <= DEADBEEF lat=%0d addr=%0d", lat, sram_addr0);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        tests_run++; if (sram_addr0 !== 9'd4) begin tests_failed++; $display("FAIL wr_addr got=%0d exp=4", sram_addr0); end
        tests_run++; if (sram_din0 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_din got=%h exp=deadbeef", sram_din0); end
        tests_run++; if (csb_low_cnt - c0 !== 1) begin tests_failed++; $display("FAIL wr_csb_cycles got=%0d exp=1", csb_low_cnt - c0); end
        tests_run++; if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL wr_ack_count got=%0d exp=1", ack_cnt - a0); end
        tests_run++; if (mem[4] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[4]); end
        a0 = ack_cnt; c0 = csb_low_cnt;
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, rd, lat);
        $display("[TB] read 3000_0010 => %h lat=%0d", rd, lat);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        tests_run++; if (csb_low_cnt - c0 !== 1) begin tests_failed++; $display("FAIL rd_csb_cycles got=%0d exp=1", csb_low_cnt - c0); end
        tests_run++; if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL rd_ack_count got=%0d exp=1", ack_cnt - a0); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, 32'h3000_0020, 32'h1122_3344, 4'hF, 1'b0, rd, lat);
        wb_xfer(1'b1, 32'h3000_0022, 32'h0000_AA00, 4'b0010, 1'b0, rd, lat);
        tests_run++; if (wbs_dat_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL dat_o_hold_on_write got=%h exp=deadbeef", wbs_dat_o); end
        wb_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0, rd, lat);
        $display("[TB] masked write sel=0010 read => %h", rd);
        tests_run++; if (rd !== 32'h1122_AA44) begin tests_failed++; $display("FAIL mask_data got=%h exp=1122aa44", rd); end
        wb_xfer(1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, lat);
        $display("[TB] sel=0 write lat=%0d", lat);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL sel0_ack got=%0d exp=2", lat); end
        wb_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0, rd, lat);
        $display("[TB] read after sel=0 write => %h", rd);
        tests_run++; if (rd !== 32'h1122_AA44) begin tests_failed++; $display("FAIL sel0_data got=%h exp=1122aa44", rd); end
    endtask

    task automatic test_miss();
        logic [31:0] adrs [3];
        logic        cycs [3];
        int a0, c0;
        adrs[0] = 32'h3000_1000; cycs[0] = 1'b1;
        adrs[1] = 32'h2000_0000; cycs[1] = 1'b1;
        adrs[2] = 32'h3000_0010; cycs[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a0 = ack_cnt; c0 = csb_low_cnt;
            wbs_cyc_i = cycs[k]; wbs_stb_i = 1'b1; wbs_we_i = k[0];
            wbs_adr_i = adrs[k]; wbs_dat_i = 32'h5555_5555; wbs_sel_i = 4'hF;
            repeat (20) @(posedge clk);
            #1;
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            $display("[TB] miss adr=%h cyc=%b acks=%0d csb_low=%0d", adrs[k], cycs[k], ack_cnt - a0, csb_low_cnt - c0);
            tests_run++; if (ack_cnt - a0 !== 0) begin tests_failed++; $display("FAIL miss_ack[%0d] got=%0d exp=0", k, ack_cnt - a0); end
            tests_run++; if (csb_low_cnt - c0 !== 0) begin tests_failed++; $display("FAIL miss_csb[%0d] got=%0d exp=0", k, csb_low_cnt - c0); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat_w, lat_r, a0, c0;
        a0 = ack_cnt; c0 = csb_low_cnt;
        wb_xfer(1'b1, 32'h3000_07FC, 32'h5A5A_C3C3, 4'hF, 1'b1, rd, lat_w);
        wb_xfer(1'b0, 32'h3000_07FC, 32'h0, 4'hF, 1'b0, rd, lat_r);
        repeat (4) @(posedge clk);
        #1;
        $display("[TB] back-to-back wr lat=%0d rd lat=%0d data=%h acks=%0d csb_low=%0d", lat_w, lat_r, rd, ack_cnt - a0, csb_low_cnt - c0);
        tests_run++; if (lat_w !== 2) begin tests_failed++; $display("FAIL b2b_wr_latency got=%0d exp=2", lat_w); end
        tests_run++; if (lat_r !== 3) begin tests_failed++; $display("FAIL b2b_rd_latency got=%0d exp=3", lat_r); end
        tests_run++; if (rd !== 32'h5A5A_C3C3) begin tests_failed++; $display("FAIL b2b_data got=%h exp=5a5ac3c3", rd); end
        tests_run++; if (ack_cnt - a0 !== 2) begin tests_failed++; $display("FAIL b2b_ack_count got=%0d exp=2", ack_cnt - a0); end
        tests_run++; if (csb_low_cnt - c0 !== 2) begin tests_failed++; $display("FAIL b2b_csb_cycles got=%0d exp=2", csb_low_cnt - c0); end
        tests_run++; if (sram_addr0 !== 9'd511) begin tests_failed++; $display("FAIL b2b_addr got=%0d exp=511", sram_addr0); end
    endtask

    task automatic test_drop();
        int a0, c0;
        a0 = ack_cnt; c0 = csb_low_cnt;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h0BAD_C0DE; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] dropped write acks=%0d csb_low=%0d mem[16]=%h", ack_cnt - a0, csb_low_cnt - c0, mem[16]);
        tests_run++; if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL drop_ack got=%0d exp=1", ack_cnt - a0); end
        tests_run++; if (csb_low_cnt - c0 !== 1) begin tests_failed++; $display("FAIL drop_csb got=%0d exp=1", csb_low_cnt - c0); end
        tests_run++; if (mem[16] !== 32'h0BAD_C0DE) begin tests_failed++; $display("FAIL drop_mem got=%h exp=0badc0de", mem[16]); end
    endtask

    task automatic test_reset_rdwait();
        logic [31:0] rd;
        int lat, a0;
        wb_xfer(1'b1, 32'h3000_001C, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat);
        a0 = ack_cnt;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_001C; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] reset in RDWAIT acks=%0d dat_o=%h csb=%b", ack_cnt - a0, wbs_dat_o, sram_csb0);
        tests_run++; if (ack_cnt - a0 !== 0) begin tests_failed++; $display("FAIL rst_rdwait_ack got=%0d exp=0", ack_cnt - a0); end
        tests_run++; if (wbs_dat_o !== 32'h0) begin tests_failed++; $display("FAIL rst_rdwait_dat_o got=%h exp=0", wbs_dat_o); end
        tests_run++; if (sram_csb0 !== 1'b1) begin tests_failed++; $display("FAIL rst_rdwait_csb got=%b exp=1", sram_csb0); end
        @(posedge clk); #1;
        wb_xfer(1'b0, 32'h3000_001C, 32'h0, 4'hF, 1'b0, rd, lat);
        $display("[TB] read after reset => %h lat=%0d", rd, lat);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL post_rst_latency got=%0d exp=3", lat); end
        tests_run++; if (rd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL post_rst_data got=%h exp=cafef00d", rd); end
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_miss();
        test_back_to_back();
        test_drop();
        test_reset_rdwait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
Wishbone B4 classic slave that gives the Caravel management SoC read/write access to port 0 (RW) of the 32x512 OpenRAM macro in the user project area. It sits directly upstream of the SRAM. It decodes a base-address window, drives the SRAM's registered control/address/data inputs and captures the negedge-launched read data. It returns a single-cycle ack to the bus.

Parameters:
BASE_ADDR, 32'h3000_0000, byte base address of the SRAM window; must be aligned to window size
ADDR_WIDTH, 9, SRAM word-address width; window = 4 << ADDR_WIDTH bytes
DATA_WIDTH, 32, bus/SRAM data width (fixed 32)
NUM_WMASKS, 4, byte-lane count (fixed DATA_WIDTH/8)

Ports:
wb_clk_i  input  1  single clock; also drives SRAM clk0
wb_rst_i  input  1  synchronous reset, active high
wbs_cyc_i  input  1  bus cycle valid
wbs_stb_i  input  1  strobe
wbs_we_i  input  1  1 = write
wbs_sel_i  input  4  byte lane selects
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  transfer ack, one-cycle pulse
wbs_dat_o  output  32  read data, valid when ack=1 for reads
sram_csb0  output  1  SRAM chip select, active low
sram_web0  output  1  SRAM write enable, active low
sram_wmask0  output  4  SRAM byte write mask
sram_addr0  output  ADDR_WIDTH  SRAM word address
sram_din0  output  32  SRAM write data
sram_dout0  input  32  SRAM read data (launched on clk0 negedge)

Behaviour:
- One clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i. All outputs are registered.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, state=IDLE.
- Hit = cyc & stb & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]). A miss is ignored: no ack, no SRAM access. Another slave or the bus timeout owns it.
- Word index = wbs_adr_i[ADDR_WIDTH+1:2]. Byte-offset bits [1:0] are ignored.
- FSM states: IDLE, ACCESS, RDWAIT, ACK.
- IDLE, hit sampled at edge E0:
  - register csb0=0, web0=~we, addr, din=wbs_dat_i;
  - wmask = we ? wbs_sel_i : 4'b0000;
  - next state ACCESS.
- ACCESS (edge E1): the SRAM captures its inputs on this edge. Controller sets csb0=1, web0=1, wmask=0.
  - Write: wbs_ack_o=1, next state ACK.
  - Read: next state RDWAIT.
- RDWAIT (edge E2): wbs_dat_o <= sram_dout0, wbs_ack_o=1, next state ACK.
- ACK: wbs_ack_o=0, next state IDLE. Requests are not sampled in ACK, so a stb still held during ack cannot cause a double access.
- Latency, counted from the request-sample edge to the edge at which the master sees ack:
  - write: 2 cycles;
  - read: 3 cycles;
  - throughput: one transfer per 3 (write) or 4 (read) cycles.
- wbs_dat_o holds its last read value between reads and is not updated on writes.
- Write with wbs_sel_i=0: SRAM access with wmask=0, memory unchanged, still acked.
- Master drops cyc/stb mid-transaction (after E0): the FSM completes the access and pulses ack anyway. The SRAM write still happens.
- Reset in any state: next edge forces the reset values. An in-flight ack is dropped. Already-captured SRAM inputs are not recalled.
- The controller never holds csb0 low for more than one cycle. It asserts at most one SRAM access per transaction.

Test Plan:
- Reset: hold wb_rst_i 2 cycles → ack=0, csb0=1, web0=1, wmask=0, dat_o=0.
- Write 0xDEADBEEF to 0x3000_0010, sel=4'hF → sram_addr0=4, csb0 low exactly 1 cycle, ack 2 cycles after request. Readback of 0x3000_0010 → dat_o=0xDEADBEEF, ack 3 cycles after request.
- Byte-masked write: sel=4'b0010, data 0x0000_AA00, to a word holding 0x11223344 → readback 0x1122AA44.
- Address outside window (0x3000_1000 with defaults) or wrong base (0x2000_0000) → no ack, csb0 stays 1 for 20 cycles.
- Back-to-back: master keeps stb high across ack and issues a read to 0x3000_07FC (word 511) immediately → exactly one ack per transfer, correct data, no duplicate csb0 pulse.
- Reset asserted in RDWAIT → ack never asserted, state IDLE, dat_o=0. The next read completes normally.
